// File: rtl/pipe_hazard_unit_if.sv
// Hazard-unit bus: Decode-side operand/destination info and the branch
// resolution flag flow in; forwarding selects, stall/flush controls and
// performance counters flow out. The pipeline drives the master side and
// the hazard unit owns the slave side.
interface pipe_hazard_unit_if #(
  parameter int DEPTH = 3,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  localparam int FW = $clog2(DEPTH);

  logic [RA_W-1:0]  rs1_d;
  logic [RA_W-1:0]  rs2_d;
  logic [RA_W-1:0]  rd_d;
  logic             regwrite_d;
  logic             load_d;
  logic             pcsrc_e;
  logic [FW-1:0]    fwd_a_e;
  logic [FW-1:0]    fwd_b_e;
  logic             stall_f;
  logic             stall_d;
  logic             flush_d;
  logic             flush_e;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs1_d, rs2_d, rd_d, regwrite_d, load_d, pcsrc_e,
    input  fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_d, rs2_d, rd_d, regwrite_d, load_d, pcsrc_e,
    output fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: tracks DEPTH post-decode stages in a shadow pipeline,
// produces operand-forwarding selects for Execute, load-use stalls and
// branch flushes. Optional saturating stall/flush performance counters are
// built only when HAZARD_PERF_CNT_EN is defined; otherwise the counter
// outputs are tied to zero.
module pipe_hazard_unit #(
  parameter int DEPTH = 3,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_unit_if.slave hz
);
  localparam int FW = $clog2(DEPTH);

  // Destination info is needed in every stage for forwarding. Source
  // registers and the load flag are only ever consulted in Execute, so only
  // entry 0 keeps them.
  logic [RA_W-1:0]  rd_q [DEPTH];
  logic [DEPTH-1:0] rw_q;
  logic [RA_W-1:0]  rs1_q;
  logic [RA_W-1:0]  rs2_q;
  logic             ld_q;

  logic [RA_W-1:0]  e0_rs1_d;
  logic [RA_W-1:0]  e0_rs2_d;
  logic [RA_W-1:0]  e0_rd_d;
  logic             e0_rw_d;
  logic             e0_ld_d;

  logic             lu_s;
  logic             stall_s;
  logic             flush_d_s;
  logic             flush_e_s;
  logic [FW-1:0]    fwd_a_s;
  logic [FW-1:0]    fwd_b_s;

  // Hazard detection and forwarding selection, gated off while in reset
  always_comb begin
    stall_s   = 1'b0;
    flush_d_s = 1'b0;
    flush_e_s = 1'b0;
    fwd_a_s   = '0;
    fwd_b_s   = '0;
    lu_s      = rw_q[0] && ld_q && (rd_q[0] != '0) &&
                ((rd_q[0] == hz.rs1_d) || (rd_q[0] == hz.rs2_d));
    if (!rst) begin
      stall_s   = 1'b0;
      flush_e_s = 1'b0;
    end else begin
      if (hz.pcsrc_e) begin
        // A taken branch kills both younger instructions and overrides any stall
        flush_d_s = 1'b1;
        flush_e_s = 1'b1;
      end else if (lu_s) begin
        stall_s   = 1'b1;
        flush_e_s = 1'b1;
      end else begin
        stall_s   = 1'b0;
      end
      // Scan oldest to youngest so the youngest matching producer wins
      for (int k = DEPTH - 1; k >= 1; k--) begin
        fwd_a_s = (rw_q[k] && (rd_q[k] != '0) && (rd_q[k] == rs1_q)) ? FW'(k) : fwd_a_s;
        fwd_b_s = (rw_q[k] && (rd_q[k] != '0) && (rd_q[k] == rs2_q)) ? FW'(k) : fwd_b_s;
      end
    end
  end

  // Next Execute entry: the Decode instruction, or a bubble when Execute is flushed
  always_comb begin
    e0_rs1_d = '0;
    e0_rs2_d = '0;
    e0_rd_d  = '0;
    e0_rw_d  = 1'b0;
    e0_ld_d  = 1'b0;
    if (flush_e_s) begin
      e0_rw_d  = 1'b0;
      e0_ld_d  = 1'b0;
    end else begin
      e0_rs1_d = hz.rs1_d;
      e0_rs2_d = hz.rs2_d;
      e0_rd_d  = hz.rd_d;
      e0_rw_d  = hz.regwrite_d;
      e0_ld_d  = hz.load_d;
    end
  end

  // Advance the shadow pipeline one stage per cycle; reset fills it with bubbles
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) rd_q[k] <= '0;
      rw_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      ld_q  <= 1'b0;
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) rd_q[k] <= rd_q[k-1];
      rd_q[0] <= e0_rd_d;
      rw_q    <= {rw_q[DEPTH-2:0], e0_rw_d};
      rs1_q   <= e0_rs1_d;
      rs2_q   <= e0_rs2_d;
      ld_q    <= e0_ld_d;
    end
  end

  assign hz.fwd_a_e = fwd_a_s;
  assign hz.fwd_b_e = fwd_b_s;
  assign hz.stall_f = stall_s;
  assign hz.stall_d = stall_s;
  assign hz.flush_d = flush_d_s;
  assign hz.flush_e = flush_e_s;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  // Saturating increments: count stall cycles and taken-branch cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_s && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (hz.pcsrc_e && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit (DEPTH=5, CNT_W=4). A driver applies
// one Decode instruction per cycle, predicts the DUT response from an
// in-flight instruction list and pushes it to a queue; a monitor pops and
// compares on the falling edge. Counter expectations follow
// HAZARD_PERF_CNT_EN exactly as the design build does.
module tb_pipe_hazard_unit;
  localparam int DEPTH = 5;
  localparam int RA_W  = 5;
  localparam int CNT_W = 4;
  localparam int FW    = $clog2(DEPTH);
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct {
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic            rw;
    logic            ld;
  } ins_t;

  typedef struct {
    logic [FW-1:0]    fa;
    logic [FW-1:0]    fb;
    logic             sf;
    logic             sd;
    logic             fd;
    logic             fe;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
    bit               cc;
    string            tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_unit_if #(.DEPTH(DEPTH), .RA_W(RA_W), .CNT_W(CNT_W)) hz ();

  pipe_hazard_unit #(.DEPTH(DEPTH), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  ins_t  inflight[$];   // index 0 = instruction in Execute, then older ones
  exp_t  sb[$];
  exp_t  last_e;
  exp_t  mon_e;
  ins_t  prev_d;
  int    stall_m   = 0;
  int    flush_m   = 0;
  bit    cnt_known = 1'b0;
  int    vectors   = 0;
  int    miscompares = 0;

  function automatic ins_t mk(int rs1, int rs2, int rd, bit rw, bit ld);
    ins_t i;
    i.rs1 = RA_W'(rs1);
    i.rs2 = RA_W'(rs2);
    i.rd  = RA_W'(rd);
    i.rw  = rw;
    i.ld  = ld;
    return i;
  endfunction

  // Youngest older instruction that writes a nonzero register equal to src
  function automatic logic [FW-1:0] producer_age(logic [RA_W-1:0] src);
    for (int k = 1; k < DEPTH; k++) begin
      if (inflight[k].rw && inflight[k].rd != 0 && inflight[k].rd == src) return FW'(k);
    end
    return '0;
  endfunction

  function automatic void chk(string tag, string field, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s %s: got %0d, expected %0d", tag, field, act, exp);
    end
  endfunction

  // One cycle of stimulus: apply inputs, predict outputs, advance the model
  task automatic step(input logic r, input ins_t d, input logic pc, input string tag);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    rst           = r;
    hz.rs1_d      = d.rs1;
    hz.rs2_d      = d.rs2;
    hz.rd_d       = d.rd;
    hz.regwrite_d = d.rw;
    hz.load_d     = d.ld;
    hz.pcsrc_e    = pc;
    e.fa = '0; e.fb = '0; e.sf = 1'b0; e.sd = 1'b0; e.fd = 1'b0; e.fe = 1'b0;
    if (r) begin
      lu = inflight[0].ld && inflight[0].rw && inflight[0].rd != 0 &&
           (inflight[0].rd == d.rs1 || inflight[0].rd == d.rs2);
      if (pc) begin
        e.fd = 1'b1; e.fe = 1'b1;
      end else if (lu) begin
        e.sf = 1'b1; e.sd = 1'b1; e.fe = 1'b1;
      end
      e.fa = producer_age(inflight[0].rs1);
      e.fb = producer_age(inflight[0].rs2);
    end
    e.sc  = CNT_W'(stall_m);
    e.fc  = CNT_W'(flush_m);
    e.cc  = cnt_known;
    e.tag = tag;
    sb.push_back(e);
    if (!r) begin
      for (int k = 0; k < DEPTH; k++) inflight[k] = mk(0, 0, 0, 0, 0);
      stall_m = 0; flush_m = 0; cnt_known = 1'b1;
    end else begin
`ifdef HAZARD_PERF_CNT_EN
      if (e.sd && stall_m < MAXC) stall_m++;
      if (pc && flush_m < MAXC) flush_m++;
`endif
      void'(inflight.pop_back());
      inflight.push_front(e.fe ? mk(0, 0, 0, 0, 0) : d);
    end
    last_e = e;
    prev_d = d;
  endtask

  // Monitor: outputs are valid every cycle; compare on the falling edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      vectors++;
      chk(mon_e.tag, "fwd_a_e", 32'(hz.fwd_a_e), 32'(mon_e.fa));
      chk(mon_e.tag, "fwd_b_e", 32'(hz.fwd_b_e), 32'(mon_e.fb));
      chk(mon_e.tag, "stall_f", 32'(hz.stall_f), 32'(mon_e.sf));
      chk(mon_e.tag, "stall_d", 32'(hz.stall_d), 32'(mon_e.sd));
      chk(mon_e.tag, "flush_d", 32'(hz.flush_d), 32'(mon_e.fd));
      chk(mon_e.tag, "flush_e", 32'(hz.flush_e), 32'(mon_e.fe));
      if (mon_e.cc) begin
        chk(mon_e.tag, "stall_cnt", 32'(hz.stall_cnt), 32'(mon_e.sc));
        chk(mon_e.tag, "flush_cnt", 32'(hz.flush_cnt), 32'(mon_e.fc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    ins_t nop;
    ins_t d;
    logic r;
    logic pc;
    nop = mk(0, 0, 0, 0, 0);
    for (int k = 0; k < DEPTH; k++) inflight.push_back(nop);
    rst = 1'b0;
    hz.rs1_d = '0; hz.rs2_d = '0; hz.rd_d = '0;
    hz.regwrite_d = 1'b0; hz.load_d = 1'b0; hz.pcsrc_e = 1'b0;

    step(1'b0, nop, 1'b0, "reset0");
    step(1'b0, mk(3, 3, 3, 1, 1), 1'b1, "reset1");

    // Forward from M, then from W with an unrelated instruction between
    step(1'b1, mk(1, 2, 5, 1, 0), 1'b0, "add_x5");
    step(1'b1, mk(5, 3, 6, 1, 0), 1'b0, "sub_x5");
    step(1'b1, mk(1, 2, 8, 1, 0), 1'b0, "fwd_a1");
    step(1'b1, mk(1, 2, 5, 1, 0), 1'b0, "add_x5b");
    step(1'b1, mk(3, 4, 10, 1, 0), 1'b0, "unrel");
    step(1'b1, mk(5, 3, 6, 1, 0), 1'b0, "sub_x5b");
    step(1'b1, nop, 1'b0, "fwd_a2");

    // Load-use on rs2: one stall, then forward from W
    step(1'b1, mk(0, 0, 7, 1, 1), 1'b0, "lw_x7");
    step(1'b1, mk(1, 7, 9, 1, 0), 1'b0, "ldu_stall");
    step(1'b1, mk(1, 7, 9, 1, 0), 1'b0, "ldu_held");
    step(1'b1, nop, 1'b0, "ldu_fwd_b2");

    // Branch in the same cycle as a load-use hazard
    step(1'b1, mk(0, 0, 7, 1, 1), 1'b0, "lw_x7b");
    step(1'b1, mk(7, 0, 9, 1, 0), 1'b1, "br_over_ldu");
    step(1'b1, nop, 1'b0, "after_br");

    // x0 is never forwarded and never causes a load-use stall
    step(1'b1, mk(0, 0, 0, 1, 0), 1'b0, "wr_x0a");
    step(1'b1, mk(0, 0, 0, 1, 0), 1'b0, "wr_x0b");
    step(1'b1, mk(0, 1, 3, 1, 0), 1'b0, "rd_x0");
    step(1'b1, nop, 1'b0, "x0_nofwd");
    step(1'b1, mk(0, 0, 0, 1, 1), 1'b0, "lw_x0");
    step(1'b1, mk(0, 0, 4, 1, 0), 1'b0, "lw_x0_use");
    step(1'b1, nop, 1'b0, "lw_x0_after");

    // x9 written in stages 2 and 4: youngest producer wins
    step(1'b1, mk(1, 1, 9, 1, 0), 1'b0, "w9_old");
    step(1'b1, mk(1, 2, 3, 1, 0), 1'b0, "gap1");
    step(1'b1, mk(2, 2, 9, 1, 0), 1'b0, "w9_young");
    step(1'b1, mk(1, 2, 4, 1, 0), 1'b0, "gap2");
    step(1'b1, mk(9, 9, 5, 1, 0), 1'b0, "use_x9");
    step(1'b1, nop, 1'b0, "x9_fwd2");

    // Reset asserted during a load-use stall
    step(1'b1, mk(0, 0, 3, 1, 1), 1'b0, "lw_x3");
    step(1'b0, mk(3, 0, 6, 1, 0), 1'b0, "rst_mid_stall");
    step(1'b1, mk(3, 0, 6, 1, 0), 1'b0, "post_rst");

    // Twenty branch cycles saturate the 4-bit flush counter
    for (int i = 0; i < 20; i++) step(1'b1, nop, 1'b1, "br_sat");
    step(1'b1, nop, 1'b0, "br_cnt");

    // Randomized traffic over a small register set; a stalled Decode is held
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 63) != 0);
      pc = ($urandom_range(0, 7) == 0);
      if (last_e.sd && !last_e.fd) begin
        d = prev_d;
      end else begin
        d.rs1 = RA_W'($urandom_range(0, 7));
        d.rs2 = RA_W'($urandom_range(0, 7));
        d.rd  = RA_W'($urandom_range(0, 7));
        d.rw  = ($urandom_range(0, 3) != 0);
        d.ld  = d.rw && ($urandom_range(0, 2) == 0);
      end
      step(r, d, pc, "random");
    end

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 3, number of tracked post-decode stages (0=E, 1=M, 2=W, ...); legal range 3..8.
REQ-002 SHALL have parameter RA_W, default 5, register-address width.
REQ-003 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-006 SHALL have ports rs1_d and rs2_d, input, RA_W, source registers of the instruction in Decode.
REQ-007 SHALL have ports rd_d, input, RA_W; regwrite_d, input, 1; load_d, input, 1 (ResultSrc selects memory), describing the Decode instruction.
REQ-008 SHALL have port pcsrc_e, input, 1, taken branch or jump resolved in Execute.
REQ-009 SHALL have ports fwd_a_e and fwd_b_e, output, clog2(DEPTH), operand-forwarding selects for Execute.
REQ-010 SHALL have ports stall_f, stall_d, flush_d and flush_e, output, 1 each.
REQ-011 SHALL have ports stall_cnt and flush_cnt, output, CNT_W each.

Function
REQ-012 SHALL hold a shadow pipeline of DEPTH entries {rs1, rs2, rd, regwrite, load}; an entry with regwrite=0 is a bubble.
REQ-013 Each cycle, entry k SHALL load entry k-1 for k=1..DEPTH-1, and entry DEPTH-1's old contents SHALL be discarded.
REQ-014 Entry 0 SHALL load the Decode inputs when flush_e=0, and SHALL load a bubble (all fields 0) when flush_e=1.
REQ-015 fwd_a_e SHALL be the smallest k in 1..DEPTH-1 with entry k regwrite=1, rd!=0 and rd==entry0.rs1; otherwise it SHALL be 0 (register file).
REQ-016 fwd_b_e SHALL be derived identically using entry0.rs2.
REQ-017 x0 SHALL never be forwarded, whatever the regwrite state.
REQ-018 A load-use hazard SHALL exist when entry 0 has load=1, regwrite=1, rd!=0, and rd equals rs1_d or rs2_d.
REQ-019 On a load-use hazard with pcsrc_e=0: stall_f=1, stall_d=1, flush_e=1 and flush_d=0, lasting exactly one cycle.
REQ-020 When pcsrc_e=1: flush_d=1, flush_e=1 and stall_f=stall_d=0; the branch SHALL suppress any simultaneous load-use stall.
REQ-021 All hazard and forward outputs SHALL be combinational from current state and inputs, with zero-cycle latency.
REQ-022 Consecutive loads with dependent consumers SHALL stall once per load and SHALL never deadlock; a bubble in entry 0 SHALL never trigger a stall.

Reset
REQ-023 While rst=0 at a clock edge, all shadow entries SHALL become bubbles and stall_cnt and flush_cnt SHALL become 0.
REQ-024 While rst=0, stall_f, stall_d, flush_d and flush_e SHALL be forced 0, and fwd_a_e and fwd_b_e SHALL read 0.
REQ-025 Reset asserted mid-stall SHALL cancel the stall in the same cycle, and the first post-reset cycle SHALL be hazard-free.

Configuration
REQ-026 With macro HAZARD_PERF_CNT_EN defined, stall_cnt SHALL increment on every cycle stall_d=1.
REQ-027 With HAZARD_PERF_CNT_EN defined, flush_cnt SHALL increment on every cycle pcsrc_e=1.
REQ-028 With HAZARD_PERF_CNT_EN defined, both counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-029 Without HAZARD_PERF_CNT_EN, both counters SHALL be constant 0, no counter flops SHALL be synthesised, and all other behaviour SHALL be unchanged.

Verification
REQ-030 Scenario: DEPTH=3; add x5 (regwrite), then sub rs1=x5 next cycle -> fwd_a_e=1 while sub is in E; one cycle later, with an unrelated instruction in between -> fwd_a_e=2.
REQ-031 Scenario: lw x7, followed by add rs2_d=x7 -> one cycle of stall_f=stall_d=flush_e=1; then fwd_b_e=2; stall_cnt=1.
REQ-032 Scenario: lw x7 in E, rs1_d=x7, pcsrc_e=1 in the same cycle -> flush_d=flush_e=1, stall_d=0, flush_cnt=1, stall_cnt=0.
REQ-033 Scenario: writes to x0 in M and W with rs1 of the E instruction = 0 -> fwd_a_e=0; lw x0 followed by a dependent read -> no stall.
REQ-034 Scenario: DEPTH=5; x9 written in stages 2 and 4 -> fwd_a_e=2 (youngest wins); assert rst=0 mid-stall -> all outputs 0 on the next edge.
REQ-035 Scenario: CNT_W=4 with the macro defined and 20 consecutive branch cycles -> flush_cnt=15; without the macro -> flush_cnt=0.
